regfile_write_arbiter: RTL and testbench

//  Shares the single write port of the 8x8 register file between two writers:

---
 rtl/regfile_write_arbiter.sv | 142 ++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Two-requester write arbiter for the 8x8 register file: one holding buffer per
// requester, oldest-first issue with round-robin tie break, registered write port.
module regfile_write_arbiter #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 3,
  parameter int RR_INIT = 0
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 REQ0_VALID,
  input  logic [ADDR_W-1:0]    REQ0_ADDR,
  input  logic [DATA_W-1:0]    REQ0_DATA,
  output logic                 REQ0_READY,
  input  logic                 REQ1_VALID,
  input  logic [ADDR_W-1:0]    REQ1_ADDR,
  input  logic [DATA_W-1:0]    REQ1_DATA,
  output logic                 REQ1_READY,
  output logic                 WR_EN,
  output logic [ADDR_W-1:0]    WR_ADDR,
  output logic [DATA_W-1:0]    WR_DATA,
  output logic [2**ADDR_W-1:0] PENDING,
  output logic [7:0]           CONFLICT_CNT
);

  logic [1:0]        buf_full_reg;
  logic [ADDR_W-1:0] buf_addr_reg [2];
  logic [DATA_W-1:0] buf_data_reg [2];
  logic              older1_reg;
  logic              tie_reg;
  logic              rr_reg;
  logic              wr_en_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [DATA_W-1:0] wr_data_reg;
  logic [7:0]        conflict_cnt_reg;

  logic [1:0]        req_valid;
  logic [ADDR_W-1:0] req_addr [2];
  logic [DATA_W-1:0] req_data [2];
  logic [1:0]        load;
  logic [1:0]        issue;
  logic [1:0]        stay;
  logic              both_full;
  logic              pick1;
  logic [ADDR_W-1:0] issue_addr_next;
  logic [DATA_W-1:0] issue_data_next;

  assign req_valid   = {REQ1_VALID, REQ0_VALID};
  assign req_addr[0] = REQ0_ADDR;
  assign req_addr[1] = REQ1_ADDR;
  assign req_data[0] = REQ0_DATA;
  assign req_data[1] = REQ1_DATA;

  assign REQ0_READY   = ~buf_full_reg[0];
  assign REQ1_READY   = ~buf_full_reg[1];
  assign WR_EN        = wr_en_reg;
  assign WR_ADDR      = wr_addr_reg;
  assign WR_DATA      = wr_data_reg;
  assign CONFLICT_CNT = conflict_cnt_reg;

  // Arbitration looks only at buffer state before the edge; a buffer accepted
  // this edge becomes eligible one edge later.
  always_comb begin
    both_full       = &buf_full_reg;
    pick1           = both_full ? (tie_reg ? rr_reg : older1_reg) : buf_full_reg[1];
    issue[0]        = buf_full_reg[0] & ~pick1;
    issue[1]        = buf_full_reg[1] & pick1;
    load            = req_valid & ~buf_full_reg;
    stay            = buf_full_reg & ~issue;
    issue_addr_next = pick1 ? buf_addr_reg[1] : buf_addr_reg[0];
    issue_data_next = pick1 ? buf_data_reg[1] : buf_data_reg[0];
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      buf_full_reg <= '0;
      for (int i = 0; i < 2; i++) begin
        buf_addr_reg[i] <= '0;
        buf_data_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (load[i]) begin
          buf_full_reg[i] <= 1'b1;
          buf_addr_reg[i] <= req_addr[i];
          buf_data_reg[i] <= req_data[i];
        end else if (issue[i]) begin
          buf_full_reg[i] <= 1'b0;
        end
      end
    end
  end

  // Age: simultaneous loads are a tie (settled by rr); otherwise the buffer
  // loaded while the other stays full is the younger one.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      older1_reg <= 1'b0;
      tie_reg    <= 1'b0;
      rr_reg     <= (RR_INIT != 0);
    end else begin
      if (load[0] && load[1]) begin
        tie_reg <= 1'b1;
      end else if (load[0]) begin
        tie_reg    <= 1'b0;
        older1_reg <= stay[1];
      end else if (load[1]) begin
        tie_reg    <= 1'b0;
        older1_reg <= ~stay[0];
      end
      if (both_full && tie_reg) begin
        rr_reg <= ~rr_reg;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_en_reg        <= 1'b0;
      wr_addr_reg      <= '0;
      wr_data_reg      <= '0;
      conflict_cnt_reg <= '0;
    end else begin
      wr_en_reg <= |buf_full_reg;
      if (|buf_full_reg) begin
        wr_addr_reg <= issue_addr_next;
        wr_data_reg <= issue_data_next;
      end
      if (both_full && conflict_cnt_reg != 8'hFF) begin
        conflict_cnt_reg <= conflict_cnt_reg + 8'd1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 2**ADDR_W; gi++) begin : g_pending
      assign PENDING[gi] = (buf_full_reg[0] && buf_addr_reg[0] == ADDR_W'(gi)) ||
                           (buf_full_reg[1] && buf_addr_reg[1] == ADDR_W'(gi)) ||
                           (wr_en_reg && wr_addr_reg == ADDR_W'(gi));
    end
  endgenerate

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a register-file model fed by WR_EN.
module tb_regfile_write_arbiter;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       REQ0_VALID, REQ1_VALID;
  logic [2:0] REQ0_ADDR, REQ1_ADDR;
  logic [7:0] REQ0_DATA, REQ1_DATA;
  logic       REQ0_READY, REQ1_READY;
  logic       WR_EN;
  logic [2:0] WR_ADDR;
  logic [7:0] WR_DATA;
  logic [7:0] PENDING;
  logic [7:0] CONFLICT_CNT;

  int checks = 0;
  int errors = 0;

  logic [7:0]  model_rf [8];
  logic [10:0] wr_log [$];

  regfile_write_arbiter #(.DATA_W(8), .ADDR_W(3), .RR_INIT(0)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ0_VALID(REQ0_VALID), .REQ0_ADDR(REQ0_ADDR), .REQ0_DATA(REQ0_DATA), .REQ0_READY(REQ0_READY),
    .REQ1_VALID(REQ1_VALID), .REQ1_ADDR(REQ1_ADDR), .REQ1_DATA(REQ1_DATA), .REQ1_READY(REQ1_READY),
    .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .PENDING(PENDING), .CONFLICT_CNT(CONFLICT_CNT)
  );

  always #5 CLK = ~CLK;

  // Writes are logged mid-cycle and committed to the model at the next edge.
  always @(negedge CLK) begin
    if (RESET && WR_EN) begin
      wr_log.push_back({WR_ADDR, WR_DATA});
    end
  end

  always @(posedge CLK) begin
    if (RESET && WR_EN) begin
      model_rf[WR_ADDR] <= WR_DATA;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    REQ0_VALID = 1'b0; REQ0_ADDR = '0; REQ0_DATA = '0;
    REQ1_VALID = 1'b0; REQ1_ADDR = '0; REQ1_DATA = '0;
  endtask

  task automatic chk_wr(string name, logic en, logic [2:0] addr, logic [7:0] data);
    checks++;
    if ({WR_EN, WR_ADDR, WR_DATA} !== {en, addr, data}) begin
      errors++;
      $display("FAIL %s: got en=%b addr=%0d data=%h, want en=%b addr=%0d data=%h",
               name, WR_EN, WR_ADDR, WR_DATA, en, addr, data);
    end else begin
      $display("ok   %s: en=%b addr=%0d data=%h", name, WR_EN, WR_ADDR, WR_DATA);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    RESET = 1'b0;
    for (int i = 0; i < 8; i++) model_rf[i] = 8'h00;
    step(); step();
    checks++;
    if ({WR_EN, WR_ADDR, WR_DATA, PENDING, CONFLICT_CNT, REQ0_READY, REQ1_READY} !==
        {1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: got en=%b addr=%0d data=%h pend=%h cnt=%0d rdy=%b%b, want zeros rdy=11",
               WR_EN, WR_ADDR, WR_DATA, PENDING, CONFLICT_CNT, REQ1_READY, REQ0_READY);
    end else begin
      $display("ok   reset_state");
    end
    RESET = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (WR_EN !== 1'b0 || REQ0_READY !== 1'b1 || REQ1_READY !== 1'b1) begin
        errors++;
        $display("FAIL idle_%0d: got en=%b rdy=%b%b, want en=0 rdy=11", i, WR_EN, REQ1_READY, REQ0_READY);
      end else begin
        $display("ok   idle_%0d", i);
      end
    end
  endtask

  task automatic test_single();
    REQ0_VALID = 1'b1; REQ0_ADDR = 3'd2; REQ0_DATA = 8'h5F;
    step();
    idle_inputs();
    checks++;
    if (REQ0_READY !== 1'b0 || WR_EN !== 1'b0 || PENDING !== 8'h04) begin
      errors++;
      $display("FAIL single_buffered: got rdy0=%b en=%b pend=%h, want 0 0 04", REQ0_READY, WR_EN, PENDING);
    end else begin
      $display("ok   single_buffered pend=%h", PENDING);
    end
    step();
    chk_wr("single_issue", 1'b1, 3'd2, 8'h5F);
    checks++;
    if (PENDING !== 8'h04 || REQ0_READY !== 1'b1) begin
      errors++;
      $display("FAIL single_pend: got pend=%h rdy0=%b, want 04 1", PENDING, REQ0_READY);
    end else begin
      $display("ok   single_pend");
    end
    step();
    chk_wr("single_done_hold", 1'b0, 3'd2, 8'h5F);
    checks++;
    if (PENDING !== 8'h00) begin
      errors++;
      $display("FAIL single_pend_clear: got %h want 00", PENDING);
    end else begin
      $display("ok   single_pend_clear");
    end
  endtask

  task automatic test_tie();
    REQ0_VALID = 1'b1; REQ0_ADDR = 3'd1; REQ0_DATA = 8'h1C;
    REQ1_VALID = 1'b1; REQ1_ADDR = 3'd4; REQ1_DATA = 8'h06;
    step();
    idle_inputs();
    checks++;
    if (PENDING !== 8'h12 || REQ0_READY !== 1'b0 || REQ1_READY !== 1'b0) begin
      errors++;
      $display("FAIL tie_loaded: got pend=%h rdy=%b%b, want 12 00", PENDING, REQ1_READY, REQ0_READY);
    end else begin
      $display("ok   tie_loaded");
    end
    step();
    chk_wr("tie_first_req0", 1'b1, 3'd1, 8'h1C);
    checks++;
    if (CONFLICT_CNT !== 8'd1 || REQ1_READY !== 1'b0 || PENDING !== 8'h12) begin
      errors++;
      $display("FAIL tie_conflict: got cnt=%0d rdy1=%b pend=%h, want 1 0 12", CONFLICT_CNT, REQ1_READY, PENDING);
    end else begin
      $display("ok   tie_conflict cnt=%0d", CONFLICT_CNT);
    end
    step();
    chk_wr("tie_second_req1", 1'b1, 3'd4, 8'h06);
    step();
    chk_wr("tie_idle", 1'b0, 3'd4, 8'h06);
    // Pointer has toggled, so the next tie favours requester 1.
    REQ0_VALID = 1'b1; REQ0_ADDR = 3'd5; REQ0_DATA = 8'h55;
    REQ1_VALID = 1'b1; REQ1_ADDR = 3'd6; REQ1_DATA = 8'h66;
    step();
    idle_inputs();
    step();
    chk_wr("tie2_first_req1", 1'b1, 3'd6, 8'h66);
    step();
    chk_wr("tie2_second_req0", 1'b1, 3'd5, 8'h55);
    checks++;
    if (CONFLICT_CNT !== 8'd2) begin
      errors++;
      $display("FAIL tie2_conflict: got %0d want 2", CONFLICT_CNT);
    end else begin
      $display("ok   tie2_conflict");
    end
    step();
  endtask

  task automatic test_same_addr();
    int n0;
    n0 = wr_log.size();
    REQ0_VALID = 1'b1; REQ0_ADDR = 3'd6; REQ0_DATA = 8'h33;
    REQ1_VALID = 1'b1; REQ1_ADDR = 3'd3; REQ1_DATA = 8'hAA;
    step();
    idle_inputs();
    step();
    chk_wr("same_blocker", 1'b1, 3'd6, 8'h33);
    REQ0_VALID = 1'b1; REQ0_ADDR = 3'd3; REQ0_DATA = 8'h0F;
    step();
    idle_inputs();
    chk_wr("same_first_AA", 1'b1, 3'd3, 8'hAA);
    checks++;
    if (PENDING !== 8'h08) begin
      errors++;
      $display("FAIL same_pend: got %h want 08", PENDING);
    end else begin
      $display("ok   same_pend");
    end
    step();
    chk_wr("same_second_0F", 1'b1, 3'd3, 8'h0F);
    step();
    checks++;
    if (wr_log.size() != n0 + 3 || wr_log[n0+1] !== {3'd3, 8'hAA} || wr_log[n0+2] !== {3'd3, 8'h0F}) begin
      errors++;
      $display("FAIL same_order: got %0d writes, want %0d with AA then 0F on reg 3", wr_log.size() - n0, 3);
    end else begin
      $display("ok   same_order");
    end
    checks++;
    if (model_rf[3] !== 8'h0F) begin
      errors++;
      $display("FAIL same_final: got reg3=%h want 0F", model_rf[3]);
    end else begin
      $display("ok   same_final reg3=%h", model_rf[3]);
    end
  endtask

  task automatic test_saturate();
    int exp_cnt;
    exp_cnt = 3;
    for (int t = 0; t < 260; t++) begin
      REQ0_VALID = 1'b1; REQ0_ADDR = 3'd0; REQ0_DATA = 8'(t);
      REQ1_VALID = 1'b1; REQ1_ADDR = 3'd7; REQ1_DATA = 8'(t + 1);
      step();
      idle_inputs();
      step(); step();
      if (exp_cnt < 255) exp_cnt++;
      if (t >= 248) begin
        checks++;
        if (CONFLICT_CNT !== 8'(exp_cnt)) begin
          errors++;
          $display("FAIL sat_%0d: got cnt=%0d want %0d", t, CONFLICT_CNT, exp_cnt);
        end else begin
          $display("ok   sat_%0d cnt=%0d", t, CONFLICT_CNT);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int n0;
    REQ0_VALID = 1'b1; REQ0_ADDR = 3'd7; REQ0_DATA = 8'hEE;
    REQ1_VALID = 1'b1; REQ1_ADDR = 3'd0; REQ1_DATA = 8'h77;
    step();
    idle_inputs();
    step();
    checks++;
    if (WR_EN !== 1'b1 || (REQ0_READY & REQ1_READY) !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_pre: got en=%b rdy=%b%b, want en=1 one buffer full", WR_EN, REQ1_READY, REQ0_READY);
    end else begin
      $display("ok   rstmid_pre");
    end
    n0 = wr_log.size();
    #1;
    RESET = 1'b0;
    #1;
    checks++;
    if ({WR_EN, PENDING, CONFLICT_CNT, REQ0_READY, REQ1_READY} !== {1'b0, 8'h00, 8'h00, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL rstmid_async: got en=%b pend=%h cnt=%0d rdy=%b%b, want 0 00 0 11",
               WR_EN, PENDING, CONFLICT_CNT, REQ1_READY, REQ0_READY);
    end else begin
      $display("ok   rstmid_async");
    end
    step();
    RESET = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (WR_EN !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_nowrite_%0d: got en=%b want 0", i, WR_EN);
      end else begin
        $display("ok   rstmid_nowrite_%0d", i);
      end
    end
    checks++;
    if (wr_log.size() != n0) begin
      errors++;
      $display("FAIL rstmid_dropped: got %0d late writes want 0", wr_log.size() - n0);
    end else begin
      $display("ok   rstmid_dropped");
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_same_addr();
    test_saturate();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
